// File: rtl/ps2_kbmat_pkg.sv
// Shared definitions for the PS/2 keyboard front end: receiver states, prefix codes, scancode map.
// Latency: n/a (types, constants and a pure combinational lookup function).
// Backpressure: n/a.
package ps2_kbmat_pkg;

   // Receiver deframing states
   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_e;

   // Scancode prefix bytes
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Result of a scancode lookup: vld says the key has a matrix position, idx is the bit
   typedef struct packed {
      logic       vld;
      logic [5:0] idx;
   } map_t;

   // Scancode-to-matrix map keyed on {extended, code}; idx = 8*line + data bit
   function automatic map_t kb_map(input logic ext, input logic [7:0] code);
      map_t m;
      m.vld = 1'b1;
      m.idx = 6'd0;
      case ({ext, code})
         9'h01C:  m.idx = 6'd37;   // A
         9'h012:  m.idx = 6'd54;   // left shift
         9'h05A:  m.idx = 6'd6;    // enter
         9'h076:  m.idx = 6'd61;   // escape
         9'h175:  m.idx = 6'd62;   // cursor up (E0 75)
         9'h029:  m.idx = 6'd46;   // space
         default: m.vld = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_kbmat_if.sv
// Bundle of the raw PS/2 pins and the keyboard matrix / error outputs.
// Latency: n/a (wiring only).
// Backpressure: none; PS/2 is device-clocked and the matrix is a level output.
interface ps2_kbmat_if;
   logic        ps2clk;
   logic        ps2dat;
   logic [63:0] kbmat_out;
   logic        frame_err;

   // master drives the pins (keyboard side) and observes the matrix
   modport master (output ps2clk, output ps2dat, input kbmat_out, input frame_err);
   // slave is the front end itself
   modport slave  (input ps2clk, input ps2dat, output kbmat_out, output frame_err);
endinterface

// File: rtl/ps2_kbmat_rx.sv
// PS/2 receiver: pin sync, falling-edge detect, 11-bit deframing FSM, inter-edge timeout.
// Latency: frame_done/frame_err pulse 3 clk edges after the stop-bit ps2clk low is first sampled.
// Backpressure: none; bytes are one-cycle pulses. Macro PS2_PARITY_CHECK_EN enables odd-parity rejection.
module ps2_kbmat_rx #(
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int TO_W           = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2clk,
   input  logic       ps2dat,
   output logic       frame_done,
   output logic [7:0] data,
   output logic       frame_err
);
   import ps2_kbmat_pkg::*;

   // [0] first sync stage, [1] synced clock, [2] synced clock one cycle earlier
   logic [2:0]      clk_sync_q;
   logic [1:0]      dat_sync_q;
   rx_state_e       state_q;
   logic [2:0]      bit_cnt_q;
   logic [7:0]      shift_q;
   logic [TO_W-1:0] to_cnt_q;
   logic            frame_done_q;
   logic            frame_err_q;
`ifdef PS2_PARITY_CHECK_EN
   logic            par_q;
`endif

   logic fall;
   logic bit_in;
   logic to_hit;
   logic par_ok;

   // Two-flop synchronisers; reset to the idle-high line level so reset never fakes an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q <= 3'b111;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], ps2clk};
         dat_sync_q <= {dat_sync_q[0], ps2dat};
      end
   end

   // Edge detect, data sample, timeout and parity evaluation
   always_comb begin
      fall   = clk_sync_q[2] & ~clk_sync_q[1];
      bit_in = dat_sync_q[1];
      // an edge in the same cycle restarts the count instead of expiring it
      to_hit = (state_q != RX_IDLE) && !fall &&
               (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`ifdef PS2_PARITY_CHECK_EN
      par_ok = ^{shift_q, par_q};
`else
      par_ok = 1'b1;
`endif
   end

   // Deframing FSM with timeout; frame_done/frame_err are registered single-cycle pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= RX_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         to_cnt_q     <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_q        <= 1'b0;
`endif
      end else begin
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;

         if (state_q == RX_IDLE || fall || to_hit)
            to_cnt_q <= '0;
         else
            to_cnt_q <= to_cnt_q + TO_W'(1);

         if (fall) begin
            case (state_q)
               RX_IDLE: begin
                  // a high start bit is treated as line noise
                  if (!bit_in) begin
                     state_q   <= RX_DATA;
                     bit_cnt_q <= 3'd0;
                  end
               end
               RX_DATA: begin
                  shift_q   <= {bit_in, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7)
                     state_q <= RX_PARITY;
               end
               RX_PARITY: begin
                  // without parity checking the bit is consumed and dropped
`ifdef PS2_PARITY_CHECK_EN
                  par_q   <= bit_in;
`endif
                  state_q <= RX_STOP;
               end
               RX_STOP: begin
                  state_q <= RX_IDLE;
                  if (bit_in && par_ok)
                     frame_done_q <= 1'b1;
                  else
                     frame_err_q  <= 1'b1;
               end
               default: state_q <= RX_IDLE;
            endcase
         end else if (to_hit) begin
            state_q     <= RX_IDLE;
            frame_err_q <= 1'b1;
         end
      end
   end

   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign data       = shift_q;

endmodule

// File: rtl/ps2_kbmat.sv
// PS/2 keyboard to Blink 64-bit key matrix (active-low bits), single clock domain.
// Latency: matrix bit changes 4 clk edges after the stop-bit ps2clk low is first sampled.
// Backpressure: none; matrix is a level output. Macro PS2_PARITY_CHECK_EN selects parity rejection in the receiver.
module ps2_kbmat #(
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int TO_W           = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   ps2_kbmat_if.slave  kb
);
   import ps2_kbmat_pkg::*;

   logic       rx_done;
   logic       rx_err;
   logic [7:0] rx_data;

   logic [63:0] mat_q, mat_d;
   logic        ext_q, ext_d;
   logic        brk_q, brk_d;
   map_t        hit;

   ps2_kbmat_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_rx (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2clk     (kb.ps2clk),
      .ps2dat     (kb.ps2dat),
      .frame_done (rx_done),
      .data       (rx_data),
      .frame_err  (rx_err)
   );

   // Scancode decoder: prefixes set flags, any other byte updates the matrix and clears them
   always_comb begin
      mat_d = mat_q;
      ext_d = ext_q;
      brk_d = brk_q;
      hit   = kb_map(ext_q, rx_data);
      if (rx_err) begin
         // a lost byte may have been part of a sequence; never let a stale prefix leak
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (rx_done) begin
         if (rx_data == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (rx_data == PS2_BRK) begin
            brk_d = 1'b1;
         end else begin
            if (hit.vld)
               mat_d[hit.idx] = brk_q;
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
   end

   // Matrix and prefix flag registers; reset releases every key
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mat_q <= '1;
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else begin
         mat_q <= mat_d;
         ext_q <= ext_d;
         brk_q <= brk_d;
      end
   end

   assign kb.kbmat_out = mat_q;
   assign kb.frame_err = rx_err;

endmodule

// File: tb/tb_ps2_kbmat.sv
// Self-checking bench for ps2_kbmat: byte-level keyboard model plus literal matrix checkpoints.
module tb_ps2_kbmat;
   localparam int T    = 200;   // shortened timeout for simulation
   localparam int HALF = 8;     // ps2clk half period in clk cycles
   localparam int GAP  = 30;    // idle cycles between frames

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   ps2_kbmat_if kif();

   ps2_kbmat #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .kb      (kif)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state
   logic [63:0] m_mat  = '1;
   logic [63:0] m_pend = '1;
   int  pend_cyc = -1;
   int  err_cyc  = -1;
   bit  m_ext = 0;
   bit  m_brk = 0;
   bit  chk_en = 0;
   int  checks = 0;
   int  errors = 0;
   int  last_fall = 0;

   int map_key [6] = '{'h01C, 'h012, 'h05A, 'h076, 'h175, 'h029};
   int map_idx [6] = '{37, 54, 6, 61, 62, 46};

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         if (pend_cyc >= 0 && cyc >= pend_cyc) begin
            m_mat    = m_pend;
            pend_cyc = -1;
         end
         checks++;
         if (kif.kbmat_out !== m_mat) begin
            errors++;
            $display("FAIL matrix cyc=%0d got %h want %h", cyc, kif.kbmat_out, m_mat);
         end
         checks++;
         if (kif.frame_err !== (cyc == err_cyc)) begin
            errors++;
            $display("FAIL frame_err cyc=%0d got %b want %b", cyc, kif.frame_err, (cyc == err_cyc));
         end
      end
   end

   task automatic check64(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   // Byte-level effect of a completed frame whose stop edge was driven at cycle k
   task automatic model_frame(input logic [7:0] b, input bit good, input int k);
      int idx;
      if (!good) begin
         err_cyc = k + 3;
         m_ext = 0;
         m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         idx = -1;
         for (int i = 0; i < 6; i++)
            if (map_key[i] == {23'd0, m_ext, b}) idx = map_idx[i];
         m_pend = m_mat;
         if (idx >= 0) m_pend[idx] = m_brk;
         pend_cyc = k + 4;
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic send_bit(input logic v);
      @(negedge clk);
      kif.ps2dat = v;
      repeat (HALF) @(negedge clk);
      kif.ps2clk = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      kif.ps2clk = 1'b1;
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      bit good;
      good = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
      good = good && !bad_par;
`endif
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      @(negedge clk);
      kif.ps2dat = ~bad_stop;
      repeat (HALF) @(negedge clk);
      kif.ps2clk = 1'b0;
      model_frame(b, good, cyc);
      repeat (HALF) @(negedge clk);
      kif.ps2clk = 1'b1;
      kif.ps2dat = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic key(input logic [7:0] b);
      frame(b, 0, 0);
   endtask

   initial begin
      kif.ps2clk = 1'b1;
      kif.ps2dat = 1'b1;
      repeat (3) @(negedge clk);
      check64("reset_matrix", kif.kbmat_out, 64'hFFFF_FFFF_FFFF_FFFF);
      checks++;
      if (kif.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_frame_err got %b want 0", kif.frame_err);
      end
      reset_n = 1'b1;
      chk_en  = 1;
      repeat (5) @(negedge clk);

      // press and release A; second press proves the break flag cleared
      key(8'h1C);
      check64("a_make", kif.kbmat_out, 64'hFFFF_FFDF_FFFF_FFFF);
      key(8'hF0); key(8'h1C);
      check64("a_break", kif.kbmat_out, 64'hFFFF_FFFF_FFFF_FFFF);
      key(8'h1C);
      check64("a_remake", kif.kbmat_out, 64'hFFFF_FFDF_FFFF_FFFF);
      key(8'hF0); key(8'h1C);

      // extended up arrow, then a plain 75 which has no mapping
      key(8'hE0); key(8'h75);
      check64("up_make", kif.kbmat_out, 64'hBFFF_FFFF_FFFF_FFFF);
      key(8'hE0); key(8'hF0); key(8'h75);
      check64("up_break", kif.kbmat_out, 64'hFFFF_FFFF_FFFF_FFFF);
      key(8'h75);
      check64("plain_75", kif.kbmat_out, 64'hFFFF_FFFF_FFFF_FFFF);

      // two keys held together, release one
      key(8'h12); key(8'h29);
      check64("shift_space", kif.kbmat_out, 64'hFFBF_BFFF_FFFF_FFFF);
      key(8'hF0); key(8'h29);
      check64("shift_only", kif.kbmat_out, 64'hFFBF_FFFF_FFFF_FFFF);
      key(8'hF0); key(8'h12);

      // wrong parity on A
      frame(8'h1C, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
      check64("bad_parity", kif.kbmat_out, 64'hFFFF_FFFF_FFFF_FFFF);
`else
      check64("bad_parity", kif.kbmat_out, 64'hFFFF_FFDF_FFFF_FFFF);
`endif
      key(8'hF0); key(8'h1C);

      // a bad stop bit drops a pending E0 or F0 prefix
      key(8'hE0); frame(8'h5A, 0, 1); key(8'h75);
      check64("ext_cleared", kif.kbmat_out, 64'hFFFF_FFFF_FFFF_FFFF);
      key(8'hF0); frame(8'h5A, 0, 1); key(8'h1C);
      check64("brk_cleared", kif.kbmat_out, 64'hFFFF_FFDF_FFFF_FFFF);
      key(8'hF0); key(8'h1C);

      // timeout after five bits, with a break prefix pending
      key(8'hF0);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      err_cyc = last_fall + 3 + T;
      m_ext = 0;
      m_brk = 0;
      kif.ps2dat = 1'b1;
      repeat (T + 20) @(negedge clk);
      key(8'h5A);
      check64("after_timeout", kif.kbmat_out, 64'hFFFF_FFFF_FFFF_FFBF);
      key(8'h76);
      check64("esc", kif.kbmat_out, 64'hDFFF_FFFF_FFFF_FFBF);

      // reset in the middle of a frame
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clk);
      chk_en  = 0;
      reset_n = 1'b0;
      #1;
      check64("mid_reset", kif.kbmat_out, 64'hFFFF_FFFF_FFFF_FFFF);
      m_mat = '1; m_pend = '1; pend_cyc = -1; err_cyc = -1; m_ext = 0; m_brk = 0;
      kif.ps2clk = 1'b1;
      kif.ps2dat = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      chk_en  = 1;
      repeat (5) @(negedge clk);
      key(8'h29);
      check64("post_reset_space", kif.kbmat_out, 64'hFFFF_BFFF_FFFF_FFFF);

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
